arr_deser_rx: RTL and testbench



---
 rtl/arr_deser_rx.sv | 155 +++++++++++++++
 tb/tb_arr_deser_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arr_deser_rx.sv
// arr_deser_rx -- receive side of the bit-serial array link.
// Takes one bit per s_valid/s_ready handshake (element 0 first, MSB first
// within each element) and rebuilds an unpacked array of packed elements.
// A shift register fills the next frame while the output register holds
// the current one; completed frames leave over m_valid/m_ready.
// Optional feature macro: ARR_DESER_RX_PARITY_EN (trailing even-parity bit
// per frame, reported on par_err alongside that frame).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and ready depends only on state.
module arr_deser_rx #(
   parameter int ELEM_W = 2,
   parameter int ELEMS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic              s_data,
   output logic              s_ready,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ELEM_W-1:0] out_arr [0:ELEMS-1],
   output logic              par_err
);

   localparam int DATA_BITS = ELEMS * ELEM_W;
`ifdef ARR_DESER_RX_PARITY_EN
   localparam int FRAME_BITS = DATA_BITS + 1;
`else
   localparam int FRAME_BITS = DATA_BITS;
`endif
   localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic {ST_FILL, ST_FULL} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic [DATA_BITS-1:0] r_out;
   logic                 r_m_valid;
   logic                 w_s_ready;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_shift_en;
   logic                 w_load_new;
   logic                 w_load_held;
   logic [DATA_BITS-1:0] w_frame_new;

   // Ready is a pure function of state so it never combinationally
   // depends on s_valid or m_ready.
   assign w_s_ready = (r_state == ST_FILL);
   assign w_accept  = s_valid && w_s_ready;
   assign w_last    = w_accept && (r_cnt == LAST_CNT);

`ifdef ARR_DESER_RX_PARITY_EN
   logic r_par_acc;
   logic r_hold_perr;
   logic r_par_err;
   logic w_perr_new;
   // The final bit is parity: it does not enter the shift register, so the
   // frame is already complete in r_shift when it arrives.
   assign w_shift_en  = w_accept && (r_cnt != LAST_CNT);
   assign w_frame_new = r_shift;
   assign w_perr_new  = r_par_acc ^ s_data;
   assign par_err     = r_par_err;
`else
   assign w_shift_en  = w_accept;
   assign w_frame_new = w_shift_nxt;
   assign par_err     = 1'b0;
`endif

   // Shift left, new bit at LSB: the first bit of a frame ends up at the MSB.
   always_comb begin
      w_shift_nxt    = '0;
      w_shift_nxt[0] = s_data;
      for (int i = 1; i < DATA_BITS; i++) begin
         w_shift_nxt[i] = r_shift[i-1];
      end
   end

   // Next state and output-register load decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_load_new  = 1'b0;
      w_load_held = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (w_last) begin
               if (!r_m_valid || m_ready) w_load_new  = 1'b1;
               else                       w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (m_ready && r_m_valid) begin
               w_load_held = 1'b1;
               w_state_nxt = ST_FILL;
            end
         end
         default: w_state_nxt = ST_FILL;
      endcase
   end

   // State, bit counter and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FILL;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         if (w_shift_en) r_shift <= w_shift_nxt;
      end
   end

   // Output register: a new or held frame keeps m_valid high with no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out     <= '0;
         r_m_valid <= 1'b0;
      end else begin
         if (w_load_new)       r_out <= w_frame_new;
         else if (w_load_held) r_out <= r_shift;
         if (w_load_new || w_load_held) r_m_valid <= 1'b1;
         else if (m_ready)               r_m_valid <= 1'b0;
      end
   end

`ifdef ARR_DESER_RX_PARITY_EN
   // Running parity per frame; the result follows its frame through the hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_par_acc   <= 1'b0;
         r_hold_perr <= 1'b0;
         r_par_err   <= 1'b0;
      end else begin
         if (w_accept) r_par_acc <= w_last ? 1'b0 : (r_par_acc ^ s_data);
         if (w_last) r_hold_perr <= w_perr_new;
         if (w_load_new)       r_par_err <= w_perr_new;
         else if (w_load_held) r_par_err <= r_hold_perr;
      end
   end
`endif

   assign s_ready = w_s_ready;
   assign m_valid = r_m_valid;

   for (genvar g = 0; g < ELEMS; g++) begin : g_unpack
      assign out_arr[g] = r_out[(ELEMS-1-g)*ELEM_W +: ELEM_W];
   end

endmodule

// File: tb/tb_arr_deser_rx.sv
// tb_arr_deser_rx -- self-checking bench for arr_deser_rx (ELEM_W=2, ELEMS=4).
// A reference model tracks frames as a queue of {parity_error, data}
// entries: head = frame on the output, second entry = frame held back.
module tb_arr_deser_rx;

  localparam int ELEM_W    = 2;
  localparam int ELEMS     = 4;
  localparam int DATA_BITS = ELEM_W * ELEMS;
`ifdef ARR_DESER_RX_PARITY_EN
  localparam int FB = DATA_BITS + 1;
`else
  localparam int FB = DATA_BITS;
`endif
  localparam int W = DATA_BITS + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_data = 1'b0;
  logic              s_ready;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [ELEM_W-1:0] out_arr [0:ELEMS-1];
  logic              par_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  exp_q[$];
  logic [FB-1:0] cur_bits;
  int            n_bits = 0;
  bit            mon_en = 1'b0;

  arr_deser_rx #(.ELEM_W(ELEM_W), .ELEMS(ELEMS)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .out_arr(out_arr), .par_err(par_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // element 0 in the top bits, as the frame was sent
  function automatic logic [DATA_BITS-1:0] out_flat();
    logic [DATA_BITS-1:0] f;
    for (int i = 0; i < ELEMS; i++) f[(ELEMS-1-i)*ELEM_W +: ELEM_W] = out_arr[i];
    return f;
  endfunction

  // frame with correct even parity appended when the feature is built in
  function automatic logic [FB-1:0] mk_frame(input logic [DATA_BITS-1:0] b);
`ifdef ARR_DESER_RX_PARITY_EN
    return {b, ^b};
`else
    return b;
`endif
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic d, input logic mr);
    s_valid = v; s_data = d; m_ready = mr;
    @(posedge clk); #1;
  endtask

  task automatic send_bits(input logic [FB-1:0] fb, input logic mr);
    for (int i = FB - 1; i >= 0; i--) drive(1'b1, fb[i], mr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
  endtask

  // scoreboard / reference model, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      automatic bit rdy = (exp_q.size() < 2);
      check("m_valid", m_valid, exp_q.size() > 0);
      check("s_ready", s_ready, rdy);
      if (exp_q.size() > 0) begin
        check("out_arr", out_flat(), exp_q[0][DATA_BITS-1:0]);
        check("par_err", par_err, exp_q[0][DATA_BITS]);
      end
      if (rst) begin
        exp_q.delete();
        n_bits = 0;
      end else begin
        if (exp_q.size() > 0 && m_ready) void'(exp_q.pop_front());
        if (s_valid && rdy) begin
          cur_bits[FB-1-n_bits] = s_data;
          n_bits++;
          if (n_bits == FB) begin
`ifdef ARR_DESER_RX_PARITY_EN
            exp_q.push_back({^cur_bits, cur_bits[FB-1 -: DATA_BITS]});
`else
            exp_q.push_back({1'b0, cur_bits[FB-1 -: DATA_BITS]});
`endif
            n_bits = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [FB-1:0] fb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // reset state
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_out", out_flat(), 0);
    check("rst_par_err", par_err, 0);

    // T1: bits 1,0,0,1,1,1,0,0 -> 10,01,11,00
    fb = mk_frame(8'h9C);
    for (int i = FB - 1; i >= 1; i--) drive(1'b1, fb[i], 1'b1);
    check("t1_no_early_valid", m_valid, 0);
    drive(1'b1, fb[0], 1'b1);
    check("t1_valid", m_valid, 1);
    check("t1_e0", out_arr[0], 2'b10);
    check("t1_e1", out_arr[1], 2'b01);
    check("t1_e2", out_arr[2], 2'b11);
    check("t1_e3", out_arr[3], 2'b00);
    idle(1);

    // T2: back-pressure, A5 held on output, 3C held in shift register
    send_bits(mk_frame(8'hA5), 1'b0);
    send_bits(mk_frame(8'h3C), 1'b0);
    check("t2_stall", s_ready, 0);
    check("t2_hold_a", out_flat(), 8'hA5);
    drive(1'b0, 1'b0, 1'b1);
    check("t2_out_b", out_flat(), 8'h3C);
    check("t2_valid_b", m_valid, 1);
    check("t2_ready_back", s_ready, 1);
    idle(1);
    check("t2_drained", m_valid, 0);

    // T3: continuous stream FF then 00, frames appear FB cycles apart
    for (int i = 1; i <= 2 * FB; i++) begin
      fb = (i <= FB) ? mk_frame(8'hFF) : mk_frame(8'h00);
      drive(1'b1, fb[FB - 1 - ((i - 1) % FB)], 1'b1);
      check("t3_no_stall", s_ready, 1);
      if (i == FB) begin
        check("t3_v_ff", m_valid, 1);
        check("t3_ff", out_flat(), 8'hFF);
      end
      if (i == 2 * FB) begin
        check("t3_v_00", m_valid, 1);
        check("t3_00", out_flat(), 8'h00);
      end
    end
    idle(1);

    // T3b: output occupied, next frame completes with m_ready high -> no bubble
    send_bits(mk_frame(8'h5A), 1'b0);
    fb = mk_frame(8'hC3);
    for (int i = FB - 1; i >= 1; i--) drive(1'b1, fb[i], 1'b0);
    check("t3b_hold", out_flat(), 8'h5A);
    drive(1'b1, fb[0], 1'b1);
    check("t3b_valid", m_valid, 1);
    check("t3b_swap", out_flat(), 8'hC3);
    idle(1);

    // T4: s_valid toggling every cycle
    fb = mk_frame(8'h9C);
    for (int i = FB - 1; i >= 0; i--) begin
      drive(1'b1, fb[i], 1'b1);
      if (i != 0) drive(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      if (i == 1) check("t4_no_early_valid", m_valid, 0);
    end
    check("t4_valid", m_valid, 1);
    check("t4_out", out_flat(), 8'h9C);
    idle(1);

    // T5: reset after 5 bits (reset wins over a simultaneous accept)
    for (int i = 0; i < 5; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_ready", s_ready, 1);
    check("t5_rst_out", out_flat(), 0);
    send_bits(mk_frame(8'h81), 1'b1);
    check("t5_e0", out_arr[0], 2'b10);
    check("t5_e3", out_arr[3], 2'b01);
    check("t5_out", out_flat(), 8'h81);
    idle(1);

    // T5b: reset while FULL discards both frames
    send_bits(mk_frame(8'h12), 1'b0);
    send_bits(mk_frame(8'h34), 1'b0);
    check("t5b_full", s_ready, 0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check("t5b_valid", m_valid, 0);
    check("t5b_ready", s_ready, 1);
    check("t5b_out", out_flat(), 0);

`ifdef ARR_DESER_RX_PARITY_EN
    // T6: parity good then bad
    send_bits({8'hA5, 1'b0}, 1'b1);
    check("t6_perr0", par_err, 0);
    check("t6_out0", out_flat(), 8'hA5);
    idle(1);
    send_bits({8'hA5, 1'b1}, 1'b1);
    check("t6_perr1", par_err, 1);
    check("t6_out1", out_flat(), 8'hA5);
    idle(1);
`endif

    // T7: randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0));
    end
    idle(2 * FB);
    check("t7_drained", m_valid, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
